// File: rtl/hour_counter.sv
// BCD hour counter 00..23 with minute-carry and manual-set increment sources.
// Define HOUR_12H_EN for 12-hour display (12,01..11) with an added pm output.
module hour_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       cin_m,
   input  logic       control,
   input  logic       st_clk,
   input  logic       st_alam,
   output logic [3:0] hour_g,
   output logic [3:0] hour_d,
`ifdef HOUR_12H_EN
   output logic       pm,
`endif
   output logic       cout_h
);

   logic [3:0] tens_q, units_q, tens_n, units_n;
   logic       cin_prev, st_prev;
   logic       set_en, cin_rise, st_rise, inc, wrap, cout_n;

   assign set_en   = control & ~st_alam;
   assign cin_rise = cin_m  & ~cin_prev;
   assign st_rise  = st_clk & ~st_prev;
   // Only the source selected by this cycle's set_en may advance the hour.
   assign inc      = set_en ? st_rise : cin_rise;
   assign wrap     = (tens_q == 4'd2) && (units_q == 4'd3);
   assign cout_n   = inc & ~set_en & wrap;

   always_comb begin
      tens_n  = tens_q;
      units_n = units_q;
      if (inc) begin
         if (wrap) begin
            tens_n  = 4'd0;
            units_n = 4'd0;
         end else if (units_q == 4'd9) begin
            tens_n  = tens_q + 4'd1;
            units_n = 4'd0;
         end else begin
            units_n = units_q + 4'd1;
         end
      end
   end

   // Previous-value flops reset high so a level already present at release is not an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         tens_q   <= 4'd0;
         units_q  <= 4'd0;
         cin_prev <= 1'b1;
         st_prev  <= 1'b1;
         cout_h   <= 1'b0;
      end else begin
         tens_q   <= tens_n;
         units_q  <= units_n;
         cin_prev <= cin_m;
         st_prev  <= st_clk;
         cout_h   <= cout_n;
      end
   end

`ifdef HOUR_12H_EN
   // Returns {pm, tens, units} of the 12-hour view of a 24-hour BCD value.
   function automatic logic [8:0] disp12(input logic [3:0] t, input logic [3:0] u);
      logic [4:0] h, h12;
      logic       hi;
      h = 5'(t) * 5'd10 + 5'(u);
      if (h == 5'd0)       h12 = 5'd12;
      else if (h > 5'd12)  h12 = h - 5'd12;
      else                 h12 = h;
      hi = (h12 >= 5'd10);
      return {(h >= 5'd12), (hi ? 4'd1 : 4'd0), (hi ? 4'(h12 - 5'd10) : 4'(h12))};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         pm     <= 1'b0;
         hour_g <= 4'd1;
         hour_d <= 4'd2;
      end else begin
         {pm, hour_g, hour_d} <= disp12(tens_n, units_n);
      end
   end
`else
   assign hour_g = tens_q;
   assign hour_d = units_q;
`endif

endmodule
